sprite_collision_detect: RTL and testbench
==========================================

// Module: sprite_collision_detect
// PURPOSE
//   Downstream consumer of the VGA pixel pipeline. Counts visible pixels per frame where the player
//   and obstacle sprites are both opaque. At vblank start it publishes the result to shared RAM over
//   a request/grant write port: a flag word, then the overlap count. Game software polls these words.
// PARAMETERS
//   COLL_FLAG_ADDR   16'hFFFC  RAM word for {overrun, 14'b0, hit}
//   COLL_COUNT_ADDR  16'hFFFD  RAM word for the saturated overlap pixel count
//   MIN_HITS         16'd4     overlap pixels needed in one frame to declare hit
//   VBLANK_LINE      10'd480   vcount value that marks frame end
// PORTS
//   sys_clk          in   1   system clock, 50 MHz
//   reset            in   1   asynchronous, active-low
//   pix_tick         in   1   one sys_clk pulse per pixel, aligned to the pix_clk rising edge
//   bright           in   1   visible-area flag from the VGA timing generator
//   hcount           in   10  current pixel column
//   vcount           in   10  current pixel line
//   player_opaque    in   1   player sprite pixel is opaque
//   obstacle_opaque  in   1   obstacle sprite pixel is opaque
//   wr_req           out  1   request for the RAM port-B write slot
//   wr_gnt           in   1   slot granted; the write occurs on this cycle
//   wr_addr          out  16  RAM write address
//   wr_data          out  16  RAM write data
//   wr_we            out  1   write enable; equals wr_req & wr_gnt
//   hit_frame        out  1   hit result of the last published frame
// BEHAVIOUR
//   Reset values: wr_req=0, wr_we=0, wr_addr=COLL_FLAG_ADDR, wr_data=0, hit_frame=0.
//   Internal reset values: acc=0, overrun=0, state=IDLE.
//   Accumulate: on pix_tick with bright & player_opaque & obstacle_opaque, acc <= acc+1.
//     acc saturates at 16'hFFFF and never wraps.
//   Frame end: on pix_tick with hcount==0 and vcount==VBLANK_LINE:
//     - snapshot cnt_lat <= acc.
//     - hit_lat <= (acc >= MIN_HITS).
//     - acc <= 0 in the same cycle. An overlapping pixel in that cycle is dropped (bright=0 there).
//   FSM states, one transition per sys_clk:
//     IDLE    : on frame end -> W_FLAG.
//     W_FLAG  : wr_req=1, wr_addr=COLL_FLAG_ADDR, wr_data={overrun,14'b0,hit_lat}.
//               On wr_gnt -> W_COUNT, and clear overrun.
//     W_COUNT : wr_req=1, wr_addr=COLL_COUNT_ADDR, wr_data=cnt_lat.
//               On wr_gnt -> IDLE, and hit_frame <= hit_lat.
//   Handshake:
//     - wr_req, wr_addr and wr_data are registered and stay stable until granted.
//     - wr_gnt without wr_req is ignored.
//     - wr_req drops in the cycle after the last grant.
//   Latency: with wr_gnt held high, the flag word is written 1 cycle after frame end and the count
//     word 1 cycle after that. wr_req is high for 2 cycles.
//   Overrun: frame end while state != IDLE:
//     - cnt_lat and hit_lat are not overwritten; the new frame result is discarded.
//     - overrun <= 1; it is reported in the next flag write.
//     - acc is still cleared.
//   Reset mid-write: all state returns to reset values at once. A pending write is abandoned.
// CONFIGURATION
//   COLLISION_IRQ_EN defined: adds ports irq out 1 and irq_ack in 1.
//     - irq is set, registered, in the cycle hit_frame is updated to 1.
//     - irq is cleared by irq_ack=1. Set wins over a simultaneous ack. Reset value 0.
//   COLLISION_IRQ_EN undefined: no irq/irq_ack ports and no irq logic; the block is polled only.
// TESTING
//   1. Reset low mid-frame, then release.
//      -> all outputs hold reset values; acc=0; first frame end writes flag 16'h0000, count 16'h0000.
//   2. 10 overlapping bright pixels, wr_gnt tied high.
//      -> FFFC<=16'h0001, then FFFD<=16'h000A on consecutive cycles; hit_frame=1.
//   3. 3 overlapping pixels, MIN_HITS=4 -> flag 16'h0000, count 16'h0003; hit_frame stays 0.
//   4. Overlaps with bright=0, or with only one sprite opaque -> count 16'h0000.
//   5. wr_gnt held low for 2 frames, then high.
//      -> first frame's count written; flag 16'h8000|hit; the next flag write shows overrun=0.
//   6. Force acc to 16'hFFFE, then 5 overlaps -> count 16'hFFFF, no wrap.
//      With COLLISION_IRQ_EN defined: irq rises, and irq_ack clears it next cycle.

Source files
------------

// File: rtl/sprite_collision_detect.sv
// Counts per-frame pixels where the player and obstacle sprites overlap, then publishes a flag word
// and the overlap count to shared RAM at vblank. Optional irq output enabled by COLLISION_IRQ_EN.
module sprite_collision_detect #(
   parameter logic [15:0] COLL_FLAG_ADDR  = 16'hFFFC,
   parameter logic [15:0] COLL_COUNT_ADDR = 16'hFFFD,
   parameter logic [15:0] MIN_HITS        = 16'd4,
   parameter logic [9:0]  VBLANK_LINE     = 10'd480
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        pix_tick,
   input  logic        bright,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        player_opaque,
   input  logic        obstacle_opaque,
   output logic        wr_req,
   input  logic        wr_gnt,
   output logic [15:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        wr_we,
   output logic        hit_frame
`ifdef COLLISION_IRQ_EN
   ,
   output logic        irq,
   input  logic        irq_ack
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      W_FLAG,
      W_COUNT
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] cnt_lat_q, cnt_lat_d;
   logic        hit_lat_q, hit_lat_d;
   logic        overrun_q, overrun_d;
   logic        wr_req_q, wr_req_d;
   logic [15:0] wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        hit_frame_q, hit_frame_d;
`ifdef COLLISION_IRQ_EN
   logic        irq_q, irq_d;
`endif

   logic frame_end;
   logic overlap;
   logic grant;

   assign frame_end = pix_tick && (hcount == 10'd0) && (vcount == VBLANK_LINE);
   assign overlap   = pix_tick && bright && player_opaque && obstacle_opaque;
   assign grant     = wr_req_q && wr_gnt;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_lat_d   = cnt_lat_q;
      hit_lat_d   = hit_lat_q;
      overrun_d   = overrun_q;
      wr_req_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      hit_frame_d = hit_frame_q;
`ifdef COLLISION_IRQ_EN
      irq_d       = irq_q;
      if (irq_ack) begin
         irq_d = 1'b0;
      end
`endif

      // Frame end takes priority: the accumulator restarts and any pixel in that cycle is dropped.
      if (frame_end) begin
         acc_d = 16'd0;
      end else if (overlap && (acc_q != 16'hFFFF)) begin
         acc_d = acc_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            if (frame_end) begin
               cnt_lat_d = acc_q;
               hit_lat_d = (acc_q >= MIN_HITS);
               state_d   = W_FLAG;
            end
         end
         W_FLAG: begin
            if (grant) begin
               state_d   = W_COUNT;
               overrun_d = 1'b0;
            end
         end
         W_COUNT: begin
            if (grant) begin
               state_d     = IDLE;
               hit_frame_d = hit_lat_q;
`ifdef COLLISION_IRQ_EN
               if (hit_lat_q) begin
                  irq_d = 1'b1;
               end
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A frame ending while a publication is still in flight is discarded but remembered;
      // setting wins over the clear from a coincident flag grant, since that flag is already out.
      if (frame_end && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_d)
         W_FLAG: begin
            wr_req_d  = 1'b1;
            wr_addr_d = COLL_FLAG_ADDR;
            wr_data_d = {overrun_d, 14'b0, hit_lat_d};
         end
         W_COUNT: begin
            wr_req_d  = 1'b1;
            wr_addr_d = COLL_COUNT_ADDR;
            wr_data_d = cnt_lat_d;
         end
         default: begin
            wr_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         acc_q       <= 16'd0;
         cnt_lat_q   <= 16'd0;
         hit_lat_q   <= 1'b0;
         overrun_q   <= 1'b0;
         wr_req_q    <= 1'b0;
         wr_addr_q   <= COLL_FLAG_ADDR;
         wr_data_q   <= 16'd0;
         hit_frame_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_lat_q   <= cnt_lat_d;
         hit_lat_q   <= hit_lat_d;
         overrun_q   <= overrun_d;
         wr_req_q    <= wr_req_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         hit_frame_q <= hit_frame_d;
      end
   end

`ifdef COLLISION_IRQ_EN
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

   assign wr_req    = wr_req_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign wr_we     = wr_req_q && wr_gnt;
   assign hit_frame = hit_frame_q;

endmodule

// File: tb/tb_sprite_collision_detect.sv
// Self-checking bench for sprite_collision_detect: directed scenarios with literal expectations
// plus randomized frames checked every cycle against a behavioural model.
module tb_sprite_collision_detect;

   logic        sys_clk = 1'b0;
   logic        reset = 1'b0;
   logic        pix_tick = 1'b0;
   logic        bright = 1'b0;
   logic [9:0]  hcount = 10'd5;
   logic [9:0]  vcount = 10'd5;
   logic        player_opaque = 1'b0;
   logic        obstacle_opaque = 1'b0;
   logic        wr_req;
   logic        wr_gnt = 1'b1;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_we;
   logic        hit_frame;
`ifdef COLLISION_IRQ_EN
   logic        irq;
   logic        irq_ack = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int fe_cyc = 0;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      int          cyc;
   } wr_t;
   wr_t wr_log[$];

   sprite_collision_detect dut (
      .sys_clk        (sys_clk),
      .reset          (reset),
      .pix_tick       (pix_tick),
      .bright         (bright),
      .hcount         (hcount),
      .vcount         (vcount),
      .player_opaque  (player_opaque),
      .obstacle_opaque(obstacle_opaque),
      .wr_req         (wr_req),
      .wr_gnt         (wr_gnt),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_we          (wr_we),
      .hit_frame      (hit_frame)
`ifdef COLLISION_IRQ_EN
      ,
      .irq            (irq),
      .irq_ack        (irq_ack)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Behavioural model: publication phase 0 = nothing pending, 1 = flag word due, 2 = count word due.
   int m_phase = 0;
   int m_acc = 0;
   int m_cnt = 0;
   bit m_hit = 1'b0;
   bit m_over = 1'b0;
   bit m_hit_frame = 1'b0;
   bit m_irq = 1'b0;
   int old_phase;
   bit granted;

   always @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         m_phase = 0;
         m_acc = 0;
         m_cnt = 0;
         m_hit = 1'b0;
         m_over = 1'b0;
         m_hit_frame = 1'b0;
         m_irq = 1'b0;
      end else begin
         old_phase = m_phase;
         granted = (m_phase != 0) && wr_gnt;
`ifdef COLLISION_IRQ_EN
         if (irq_ack) m_irq = 1'b0;
`endif
         if (old_phase == 1 && granted) begin
            m_phase = 2;
            m_over = 1'b0;
         end else if (old_phase == 2 && granted) begin
            m_phase = 0;
            m_hit_frame = m_hit;
            if (m_hit) m_irq = 1'b1;
         end
         if (pix_tick && hcount == 10'd0 && vcount == 10'd480) begin
            if (old_phase == 0) begin
               m_cnt = m_acc;
               m_hit = (m_acc >= 4);
               m_phase = 1;
            end else begin
               m_over = 1'b1;
            end
            m_acc = 0;
         end else if (pix_tick && bright && player_opaque && obstacle_opaque) begin
            if (m_acc < 65535) m_acc = m_acc + 1;
         end
      end
   end

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   always @(negedge sys_clk) begin
      checkOutput("wr_req", 32'(wr_req), 32'(m_phase != 0));
      checkOutput("wr_we", 32'(wr_we), 32'((m_phase != 0) && wr_gnt));
      checkOutput("hit_frame", 32'(hit_frame), 32'(m_hit_frame));
      if (m_phase == 1) begin
         checkOutput("flag_addr", 32'(wr_addr), 32'h0000_FFFC);
         checkOutput("flag_data", 32'(wr_data), 32'({m_over, 14'b0, m_hit}));
      end else if (m_phase == 2) begin
         checkOutput("count_addr", 32'(wr_addr), 32'h0000_FFFD);
         checkOutput("count_data", 32'(wr_data), 32'(m_cnt));
      end
`ifdef COLLISION_IRQ_EN
      checkOutput("irq", 32'(irq), 32'(m_irq));
`endif
      if (wr_we) wr_log.push_back('{addr: wr_addr, data: wr_data, cyc: cyc});
   end

   task automatic applyStimulus(input bit t, input bit b, input bit p, input bit o,
                                input logic [9:0] h, input logic [9:0] v);
      pix_tick = t;
      bright = b;
      player_opaque = p;
      obstacle_opaque = o;
      hcount = h;
      vcount = v;
      @(posedge sys_clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd7, 10'd7);
   endtask

   task automatic overlapPixels(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'((i % 600) + 1), 10'd100);
   endtask

   task automatic frameEnd();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd480);
      fe_cyc = cyc;
   endtask

   // Expects exactly one flag write then one count write on back-to-back cycles.
   task automatic expectWrites(input string nm, input logic [15:0] fd, input logic [15:0] cd,
                               input bit check_latency);
      checkOutput({nm, "_nwrites"}, 32'(wr_log.size()), 32'd2);
      if (wr_log.size() >= 2) begin
         checkOutput({nm, "_flag_addr"}, 32'(wr_log[0].addr), 32'h0000_FFFC);
         checkOutput({nm, "_flag_data"}, 32'(wr_log[0].data), 32'(fd));
         checkOutput({nm, "_count_addr"}, 32'(wr_log[1].addr), 32'h0000_FFFD);
         checkOutput({nm, "_count_data"}, 32'(wr_log[1].data), 32'(cd));
         checkOutput({nm, "_consecutive"}, 32'(wr_log[1].cyc), 32'(wr_log[0].cyc + 1));
         if (check_latency) checkOutput({nm, "_latency"}, 32'(wr_log[0].cyc), 32'(fe_cyc));
      end
      wr_log.delete();
   endtask

   initial begin
      // 1: reset mid-frame with a publication pending; nothing stale may be written afterwards.
      idle(3);
      reset = 1'b1;
      idle(2);
      wr_gnt = 1'b0;
      overlapPixels(4);
      frameEnd();
      overlapPixels(6);
      reset = 1'b0;
      #1;
      checkOutput("rst_wr_req", 32'(wr_req), 32'd0);
      checkOutput("rst_wr_we", 32'(wr_we), 32'd0);
      checkOutput("rst_wr_addr", 32'(wr_addr), 32'h0000_FFFC);
      checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
      checkOutput("rst_hit_frame", 32'(hit_frame), 32'd0);
      idle(2);
      reset = 1'b1;
      wr_gnt = 1'b1;
      wr_log.delete();
      idle(2);
      frameEnd();
      idle(4);
      expectWrites("t1", 16'h0000, 16'h0000, 1'b1);

      // 3: below threshold
      overlapPixels(3);
      frameEnd();
      idle(4);
      expectWrites("t3", 16'h0000, 16'h0003, 1'b1);
      checkOutput("t3_hit_frame", 32'(hit_frame), 32'd0);

      // 2: hit
      overlapPixels(10);
      frameEnd();
      idle(4);
      expectWrites("t2", 16'h0001, 16'h000A, 1'b1);
      checkOutput("t2_hit_frame", 32'(hit_frame), 32'd1);

      // 4: pixels that must not count
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 10'(i + 1), 10'd50);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'(i + 1), 10'd50);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 10'(i + 1), 10'd50);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'(i + 1), 10'd50);
      frameEnd();
      idle(4);
      expectWrites("t4", 16'h0000, 16'h0000, 1'b1);
      checkOutput("t4_hit_frame", 32'(hit_frame), 32'd0);

      // 5: grant withheld across two frame ends
      wr_gnt = 1'b0;
      overlapPixels(7);
      frameEnd();
      overlapPixels(2);
      frameEnd();
      idle(3);
      wr_gnt = 1'b1;
      idle(4);
      expectWrites("t5_overrun", 16'h8001, 16'h0007, 1'b0);
      frameEnd();
      idle(4);
      expectWrites("t5_next", 16'h0000, 16'h0000, 1'b1);

      // 6: saturation
`ifdef COLLISION_IRQ_EN
      irq_ack = 1'b1;
      idle(1);
      irq_ack = 1'b0;
      checkOutput("t6_irq_acked", 32'(irq), 32'd0);
`endif
      overlapPixels(65534 + 5);
      frameEnd();
      idle(4);
      expectWrites("t6", 16'h0001, 16'hFFFF, 1'b1);
`ifdef COLLISION_IRQ_EN
      checkOutput("t6_irq_set", 32'(irq), 32'd1);
      irq_ack = 1'b1;
      idle(1);
      irq_ack = 1'b0;
      checkOutput("t6_irq_clear", 32'(irq), 32'd0);
`endif

      // Randomized frames with random grants and occasional resets; the model checks every cycle.
      for (int f = 0; f < 60; f++) begin
         int npix;
         npix = int'($urandom_range(3, 20));
         for (int i = 0; i < npix; i++) begin
            wr_gnt = ($urandom_range(0, 2) != 0);
`ifdef COLLISION_IRQ_EN
            irq_ack = ($urandom_range(0, 7) == 0);
`endif
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
         end
         wr_gnt = ($urandom_range(0, 2) != 0);
         applyStimulus(1'b1, $urandom_range(0, 1) != 0, 1'b1, 1'b1, 10'd0, 10'd480);
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b0;
            idle(1);
            reset = 1'b1;
         end
      end
      wr_gnt = 1'b1;
`ifdef COLLISION_IRQ_EN
      irq_ack = 1'b0;
`endif
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
